uart_fifo_core: RTL and testbench
=================================

// Module: uart_fifo_core
// PURPOSE
//  Parametrised successor to the single-byte UART top. Contains an integer baud divider with 16x RX oversampling,
//  a TX path and an RX path, each with an N-deep FIFO. Frames are configurable in width, with optional parity.
//  Sits between a CPU/bus-side byte interface and the board serial pins.
//  Adds framing and overrun error flags, RX start-bit glitch rejection and FIFO buffering in both directions.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency, Hz
//  BAUD        115_200     line rate, bit/s
//  DATA_BITS   8           payload bits per frame, 5..9
//  FIFO_DEPTH  16          entries per FIFO, power of two, >=2
//  PARITY_ODD  0           0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined
// PORTS
//  clk            in   1          single clock, rising edge
//  reset          in   1          synchronous, active-high
//  wr_enb         in   1          push data_in into TX FIFO
//  data_in        in   DATA_BITS  TX byte
//  tx_full        out  1          TX FIFO full (registered)
//  tx_active      out  1          frame on line: start..stop bit
//  tx_serial_out  out  1          serial TX line, idle high
//  rx_serial_in   in   1          serial RX line, asynchronous
//  rd_enb         in   1          pop RX FIFO head
//  rx_data_out    out  DATA_BITS  RX FIFO head (first-word fall-through)
//  rx_empty       out  1          RX FIFO empty
//  rx_overrun     out  1          sticky: frame lost because RX FIFO full
//  rx_frame_err   out  1          1-cycle pulse: stop bit sampled 0
//  rx_parity_err  out  1          1-cycle pulse: parity mismatch (tied 0 without macro)
//  clr_err        in   1          clears rx_overrun
// BEHAVIOUR
//  - Timing: DIV = CLK_HZ/(BAUD*16), truncated, minimum 1. rx_tick fires once every DIV clks.
//    A TX bit lasts 16*DIV clks.
//  - Reset, next edge: tx_serial_out=1; tx_active=0; tx_full=0; rx_empty=1; rx_data_out=0; all error flags 0.
//    FIFOs, FSMs and dividers are cleared. A frame in flight is abandoned; no partial bits persist.
//  - TX FIFO:
//    - a write with wr_enb=1 and tx_full=0 is stored; a write while tx_full=1 is dropped silently,
//      even if a pop happens in the same cycle.
//  - TX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - IDLE pops the FIFO when it is non-empty; START begins the next clk.
//    - Data is sent LSB first, DATA_BITS bits, followed by 1 stop bit.
//    - tx_active is 1 from the first START clk through the last STOP clk.
//    - Back-to-back frames have 1 idle clk between them.
//  - RX synchroniser: 2-FF on rx_serial_in, reset value 1.
//  - RX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - IDLE: a falling edge starts an oversample count.
//    - START: re-checks the line at sample 8. If the line is 1, the event is a glitch:
//      return to IDLE with no flag.
//    - Each later bit is sampled at its sample-8 point.
//    - STOP: line 1 -> the word is pushed. Line 0 -> rx_frame_err pulses and the word is discarded.
//      In both cases the FSM returns to IDLE.
//  - RX push when FIFO full:
//    - without rd_enb in the same cycle, the word is dropped and rx_overrun sets;
//    - with rd_enb in the same cycle, both the pop and the push occur and no overrun is flagged.
//  - rx_overrun is cleared by clr_err. If a new overrun and clr_err coincide, the set wins.
//  - rd_enb with rx_empty=1 is ignored. rx_data_out updates the clk after a pop.
//  - FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty come from the MSB compare.
// CONFIGURATION
//  - UART_PARITY_EN defined:
//    - TX inserts a parity bit after the data bits, even or odd per PARITY_ODD.
//    - RX checks it. On mismatch, rx_parity_err pulses and the word is still pushed.
//    - Frame = 1 + DATA_BITS + 1 + 1 bits.
//  - UART_PARITY_EN undefined:
//    - no PARITY state; rx_parity_err is constant 0; frame = DATA_BITS + 2 bits.
// TESTING  (CLK_HZ=1_600_000, BAUD=100_000 -> DIV=1, 16 clk/bit, DATA_BITS=8, DEPTH=16, loopback tx->rx unless noted)
//  1. Write 0xA5 once -> tx_active high for 160 clk; tx_serial_out bits: 0,1,0,1,0,0,1,0,1,1;
//     rx_empty falls within 165 clk of the write; rx_data_out=0xA5.
//  2. 18 back-to-back writes 0x00..0x11 -> tx_full=1 after the 17th write; 0x11 dropped;
//     exactly 17 frames sent, 0x00..0x10 in order.
//  3. No rd_enb; 17 frames received -> FIFO holds the first 16; rx_overrun=1; 17th lost;
//     clr_err pulse -> rx_overrun=0.
//  4. Drive frame 0x3C with stop bit 0 -> one rx_frame_err pulse; rx_empty stays 1;
//     a following good frame 0x3C is received correctly.
//  5. rx low pulse of 5 clk, then high -> no pulse on rx_empty or any error flag.
//     Then reset at TX data bit 3 -> next clk tx_serial_out=1, tx_active=0, tx_full=0, rx_empty=1.
//  6. UART_PARITY_EN, PARITY_ODD=0: send 0x07 -> parity bit 1 on the line.
//     Inject the same frame with parity 0 -> rx_parity_err pulses once and 0x07 is still pushed.

Source files
------------

// File: rtl/uart_fifo_core.sv
// UART core: integer baud divider, FIFO-buffered TX and 16x-oversampled RX with framing/overrun errors.
// Define UART_PARITY_EN to add a parity bit (even/odd per PARITY_ODD) to every frame.
module uart_fifo_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_enb,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_full,
  output logic                 tx_active,
  output logic                 tx_serial_out,
  input  logic                 rx_serial_in,
  input  logic                 rd_enb,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_empty,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 clr_err
);
  localparam int DIV_RAW  = CLK_HZ / (BAUD * 16);
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BIT_CLKS = 16 * DIV;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(BIT_CLKS);
  localparam int DCW      = $clog2(DIV) + 1;
  localparam int BW       = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_fifo_core: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_fifo_core: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_fifo_core: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp;
  logic                 tx_empty, tx_push, tx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_push  = wr_enb && !tx_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tx_push) tx_mem[tx_wp[AW-1:0]] <= data_in;
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_bit_end, tx_line;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_bit_end = (tx_cnt == CW'(BIT_CLKS - 1));

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_next = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end && tx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          tx_next = S_PAR;
`else
          tx_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (tx_bit_end) tx_next = S_IDLE;
      end
      default: tx_next = S_IDLE;
    endcase
  end

  // Line and activity are re-registered so both shift together and stay glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state      <= S_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_shift      <= '0;
      tx_serial_out <= 1'b1;
      tx_active     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par        <= 1'b0;
`endif
    end else begin
      tx_state      <= tx_next;
      tx_cnt        <= (tx_state == S_IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
      tx_serial_out <= tx_line;
      tx_active     <= (tx_state != S_IDLE);
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rp[AW-1:0]];
        tx_bit   <= '0;
`ifdef UART_PARITY_EN
        tx_par   <= (^tx_mem[tx_rp[AW-1:0]]) ^ 1'(PARITY_ODD);
`endif
      end else if (tx_state == S_DATA && tx_bit_end) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  // ---------------- RX synchroniser and oversample divider ----------------
  logic           rx_meta, rx_s, rx_d, rx_fall, rx_tick, rx_restart;
  logic [DCW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_serial_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_fall = rx_d && !rx_s;
  assign rx_tick = (div_cnt == DCW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || rx_restart || rx_tick) div_cnt <= '0;
    else                                div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- RX FSM ----------------
  state_t               rx_state, rx_next;
  logic [3:0]           rx_os;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_bit_smp, rx_data_smp, rx_stop_smp;

  assign rx_bit_smp  = rx_tick && (rx_os == 4'd15);
  assign rx_data_smp = (rx_state == S_DATA) && rx_bit_smp;
  assign rx_stop_smp = (rx_state == S_STOP) && rx_bit_smp;

  always_comb begin
    rx_next    = rx_state;
    rx_restart = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_fall) begin
          rx_next    = S_START;
          rx_restart = 1'b1;
        end
      end
      // Mid-start re-check rejects short low glitches.
      S_START: begin
        if (rx_tick && rx_os == 4'd7) rx_next = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_bit_smp && rx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          rx_next = S_PAR;
`else
          rx_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (rx_bit_smp) rx_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (rx_bit_smp) rx_next = S_IDLE;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= S_IDLE;
      rx_os        <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_next;
      rx_frame_err <= rx_stop_smp && !rx_s;
      if (rx_state == S_IDLE || (rx_state == S_START && rx_next != S_START)) rx_os <= '0;
      else if (rx_tick)                                                     rx_os <= rx_os + 1'b1;
      if (rx_state == S_START) rx_bit <= '0;
      if (rx_data_smp) begin
        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) rx_parity_err <= 1'b0;
    else       rx_parity_err <= (rx_state == S_PAR) && rx_bit_smp &&
                                (rx_s != ((^rx_shift) ^ 1'(PARITY_ODD)));
  end
`else
  assign rx_parity_err = 1'b0;
`endif

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp, rx_rp;
  logic                 rx_full, rx_push, rx_pop, rx_do_push;

  assign rx_empty    = (rx_wp == rx_rp);
  assign rx_full     = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_push     = rx_stop_smp && rx_s;
  assign rx_pop      = rd_enb && !rx_empty;
  assign rx_do_push  = rx_push && (!rx_full || rx_pop);
  assign rx_data_out = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_do_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)     rx_rp <= rx_rp + 1'b1;
      if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
      else if (clr_err)                  rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rx_do_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at 16 clk/bit, mostly in tx->rx loopback.
`timescale 1ns/1ps
module tb_uart_fifo_core;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int ACT_LEN = FRAME_BITS * 16;
  localparam int BURST_BOUND = 17 * (ACT_LEN + 1) + 300;

  logic       clk = 1'b0, reset = 1'b1, wr_enb = 1'b0, rd_enb = 1'b0, clr_err = 1'b0;
  logic       loop_en = 1'b1, rx_drv = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       tx_full, tx_active, tx_serial_out, rx_serial_in, rx_empty;
  logic       rx_overrun, rx_frame_err, rx_parity_err;
  logic [7:0] rx_data_out;

  assign rx_serial_in = loop_en ? tx_serial_out : rx_drv;
  always #5 clk = ~clk;

  uart_fifo_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .wr_enb(wr_enb), .data_in(data_in), .tx_full(tx_full),
    .tx_active(tx_active), .tx_serial_out(tx_serial_out), .rx_serial_in(rx_serial_in),
    .rd_enb(rd_enb), .rx_data_out(rx_data_out), .rx_empty(rx_empty), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .clr_err(clr_err)
  );

  int   n_checks = 0, n_fail = 0;
  int   fe_cnt = 0, pe_cnt = 0, tx_rise_cnt = 0;
  logic ne_seen = 1'b0, mon_clr = 1'b0, tx_act_d = 1'b0;

  always @(negedge clk) begin
    tx_act_d <= tx_active;
    if (mon_clr) begin
      fe_cnt <= 0; pe_cnt <= 0; tx_rise_cnt <= 0; ne_seen <= 1'b0;
    end else begin
      if (rx_frame_err)            fe_cnt      <= fe_cnt + 1;
      if (rx_parity_err)           pe_cnt      <= pe_cnt + 1;
      if (!rx_empty)               ne_seen     <= 1'b1;
      if (tx_active && !tx_act_d)  tx_rise_cnt <= tx_rise_cnt + 1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1; cyc(); cyc(); mon_clr = 1'b0;
  endtask

  task automatic pop();
    rd_enb = 1'b1; cyc(); rd_enb = 1'b0;
  endtask

  // pd[8] is the parity bit, only driven when the frame carries one.
  task automatic send_frame(input logic [8:0] pd, input logic stop);
    rx_drv = 1'b0; repeat (16) cyc();
    for (int i = 0; i < 8; i++) begin
      rx_drv = pd[i]; repeat (16) cyc();
    end
    if (FRAME_BITS == 11) begin
      rx_drv = pd[8]; repeat (16) cyc();
    end
    rx_drv = stop; repeat (16) cyc();
    rx_drv = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line_np;   // line bits, bit i = i-th bit on the wire, no parity
    logic [10:0] line_p;    // same with even parity bit
  } vec_t;
  vec_t        vecs [5];
  logic [10:0] line, exp_line;
  int          act, t_empty, got[$];

  initial begin
    vecs[0] = '{8'hA5, 11'h34A, 11'h54A};
    vecs[1] = '{8'h00, 11'h200, 11'h400};
    vecs[2] = '{8'hFF, 11'h3FE, 11'h5FE};
    vecs[3] = '{8'h07, 11'h20E, 11'h60E};
    vecs[4] = '{8'h3C, 11'h278, 11'h478};

    reset = 1'b1; cyc();
    check("rst_txd",     32'(tx_serial_out), 32'd1);
    check("rst_active",  32'(tx_active),     32'd0);
    check("rst_full",    32'(tx_full),       32'd0);
    check("rst_empty",   32'(rx_empty),      32'd1);
    check("rst_rxdata",  32'(rx_data_out),   32'd0);
    check("rst_errs",    32'({rx_overrun, rx_frame_err, rx_parity_err}), 32'd0);
    cyc(); reset = 1'b0; cyc();

    // Single frames in loopback: line shape, frame length, RX latency and data.
    for (int v = 0; v < 5; v++) begin
`ifdef UART_PARITY_EN
      exp_line = vecs[v].line_p;
`else
      exp_line = vecs[v].line_np;
`endif
      wr_enb = 1'b1; data_in = vecs[v].data; cyc(); wr_enb = 1'b0;
      line = '0; act = 0; t_empty = -1;
      for (int c = 1; c <= 260; c++) begin
        cyc();
        if (tx_active) begin
          if (act % 16 == 8 && act / 16 < 11) line[act / 16] = tx_serial_out;
          act++;
        end
        if (!rx_empty && t_empty < 0) t_empty = c;
        if (act > 0 && !tx_active && t_empty >= 0) break;
      end
      check("vec_line",   32'(line),     32'(exp_line));
      check("vec_active", 32'(act),      32'(ACT_LEN));
      check("vec_rx_lat", 32'(t_empty > 0 && t_empty <= ACT_LEN + 5), 32'd1);
      check("vec_rxdata", 32'(rx_data_out), 32'(vecs[v].data));
      pop();
      check("vec_popped", 32'(rx_empty), 32'd1);
      repeat (4) cyc();
    end

    // 18 back-to-back writes: 17th fills the TX FIFO, 18th is dropped.
    clear_mon();
    for (int i = 0; i < 18; i++) begin
      wr_enb = 1'b1; data_in = 8'(i); cyc();
      if (i == 15) check("burst_full16", 32'(tx_full), 32'd0);
      if (i == 16) check("burst_full17", 32'(tx_full), 32'd1);
      if (i == 17) check("burst_full18", 32'(tx_full), 32'd1);
    end
    wr_enb = 1'b0;
    got.delete();
    for (int c = 0; c < BURST_BOUND; c++) begin
      if (!rx_empty && !rd_enb) begin
        got.push_back(int'(rx_data_out)); rd_enb = 1'b1;
      end else rd_enb = 1'b0;
      cyc();
    end
    rd_enb = 1'b0;
    check("burst_rx_count", 32'(got.size()), 32'd17);
    check("burst_tx_count", 32'(tx_rise_cnt), 32'd17);
    for (int i = 0; i < 17; i++)
      check("burst_order", 32'((i < got.size()) ? got[i] : -1), 32'(i));

    // RX overrun: 17 frames with no reads, then clear.
    for (int i = 0; i < 17; i++) begin
      wr_enb = 1'b1; data_in = 8'h40 + 8'(i); cyc();
    end
    wr_enb = 1'b0;
    for (int c = 0; c < BURST_BOUND && !rx_overrun; c++) cyc();
    repeat (30) cyc();
    check("ovr_set",    32'(rx_overrun), 32'd1);
    check("ovr_tx_idle", 32'(tx_active), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("ovr_data", 32'(rx_data_out), 32'h40 + 32'(i));
      pop();
    end
    check("ovr_17th_lost", 32'(rx_empty), 32'd1);
    check("ovr_sticky",    32'(rx_overrun), 32'd1);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    check("ovr_cleared",   32'(rx_overrun), 32'd0);

    // Bad stop bit, then a good frame.
    loop_en = 1'b0; rx_drv = 1'b1; clear_mon();
    send_frame({1'b0, 8'h3C}, 1'b0);
    repeat (30) cyc();
    check("ferr_pulses",   32'(fe_cnt),  32'd1);
    check("ferr_no_push",  32'(ne_seen), 32'd0);
    send_frame({1'b0, 8'h3C}, 1'b1);
    repeat (30) cyc();
    check("ferr_good_nonempty", 32'(rx_empty),    32'd0);
    check("ferr_good_data",     32'(rx_data_out), 32'h3C);
    check("ferr_no_new_pulse",  32'(fe_cnt),      32'd1);
    pop();

    // Short start glitch must be ignored.
    clear_mon();
    rx_drv = 1'b0; repeat (5) cyc(); rx_drv = 1'b1;
    repeat (40) cyc();
    check("glitch_no_push", 32'(ne_seen), 32'd0);
    check("glitch_no_err",  32'(fe_cnt + pe_cnt), 32'd0);

    // Reset in the middle of TX data bit 3 (0xA5 bit 3 is 0 on the line).
    loop_en = 1'b1;
    wr_enb = 1'b1; data_in = 8'hA5; cyc(); wr_enb = 1'b0;
    for (int c = 0; c < 20 && !tx_active; c++) cyc();
    repeat (70) cyc();
    check("midrst_line_low", 32'(tx_serial_out), 32'd0);
    reset = 1'b1; cyc();
    check("midrst_txd",    32'(tx_serial_out), 32'd1);
    check("midrst_active", 32'(tx_active),     32'd0);
    check("midrst_full",   32'(tx_full),       32'd0);
    check("midrst_empty",  32'(rx_empty),      32'd1);
    reset = 1'b0; clear_mon();
    repeat (200) cyc();
    check("midrst_no_frame", 32'(ne_seen | tx_active), 32'd0);

`ifdef UART_PARITY_EN
    // Wrong parity: flagged once, word still stored.
    loop_en = 1'b0; clear_mon();
    send_frame({1'b0, 8'h07}, 1'b1);
    repeat (30) cyc();
    check("par_pulses", 32'(pe_cnt),      32'd1);
    check("par_no_fe",  32'(fe_cnt),      32'd0);
    check("par_pushed", 32'(rx_data_out), 32'h07);
    pop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
